// File: rtl/dbp_bht_ctrl.sv
// Branch history table sequencer: channel 1 serves fetch lookups, channel 2 runs
// queued 2-bit counter read-modify-write updates and the full-table clear sweep.
module dbp_bht_ctrl #(
  parameter int                AWIDTH  = 10,
  parameter int                DWIDTH  = 32,
  parameter int                SW      = 4,
  parameter int                QDEPTH  = 4,
  parameter logic [DWIDTH-1:0] CLR_PAT = {(DWIDTH/2){2'b01}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AWIDTH+SW-1:0] lkp_idx,
  output logic [1:0]           lkp_ctr,
  output logic                 lkp_taken,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [AWIDTH+SW-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic                 clr_req,
  output logic                 busy,
  output logic [AWIDTH-1:0]    bht_add1,
  input  logic [DWIDTH-1:0]    bht_rdata1,
  output logic [AWIDTH-1:0]    bht_add2,
  input  logic [DWIDTH-1:0]    bht_rdata2,
  output logic                 bht_wen2,
  output logic [DWIDTH-1:0]    bht_wdata2
);
  localparam int IW = AWIDTH + SW;
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [QW-1:0]     PTR_ONE  = QW'(1);
  localparam logic [QW:0]       CNT_ONE  = (QW+1)'(1);
  localparam logic [QW:0]       CNT_FULL = (QW+1)'(QDEPTH);
  localparam logic [AWIDTH-1:0] CNT_LAST = '1;
  localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);

  typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

  state_t            state_reg, state_next;
  logic              clr_pend_reg;
  logic [AWIDTH-1:0] clr_cnt_reg;
  logic [SW-1:0]     slot_q_reg;
  logic [IW:0]       upd_q_reg;

  logic [IW:0]       fifo_mem [QDEPTH];
  logic [QW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [QW:0]       count_reg;

  logic fifo_full, fifo_empty, push, pop, flush;

  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign upd_ready  = !fifo_full && (state_reg != CLR);
  assign push       = upd_valid && upd_ready;
  assign pop        = (state_reg == IDLE) && !clr_pend_reg && !fifo_empty;
  assign flush      = (state_reg == IDLE) && clr_pend_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

  // Lookup channel: word address is combinational, slot follows the registered read.
  assign bht_add1  = lkp_idx[IW-1:SW];
  assign lkp_ctr   = bht_rdata1[{slot_q_reg, 1'b0} +: 2];
  assign lkp_taken = lkp_ctr[1];

  // Update FIFO storage holds {idx, taken}; a flush beats a same-cycle push.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {upd_idx, upd_taken};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Read-modify-write datapath: only the addressed slot is replaced.
  logic [AWIDTH-1:0] upd_word;
  logic [SW-1:0]     upd_slot;
  logic              upd_dir;
  logic [1:0]        cur_ctr, new_ctr;
  logic [DWIDTH-1:0] rmw_word;

  assign upd_word = upd_q_reg[IW:SW+1];
  assign upd_slot = upd_q_reg[SW:1];
  assign upd_dir  = upd_q_reg[0];
  assign cur_ctr  = bht_rdata2[{upd_slot, 1'b0} +: 2];
  assign new_ctr  = upd_dir ? ((cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01)
                            : ((cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01);

  generate
    for (genvar gi = 0; gi < DWIDTH/2; gi++) begin : g_slot
      assign rmw_word[2*gi +: 2] = (upd_slot == SW'(gi)) ? new_ctr : bht_rdata2[2*gi +: 2];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    bht_add2   = '0;
    bht_wen2   = 1'b0;
    bht_wdata2 = '0;
    case (state_reg)
      IDLE: begin
        if (clr_pend_reg)     state_next = CLR;
        else if (!fifo_empty) state_next = RD;
      end
      RD: begin
        bht_add2   = upd_word;
        state_next = WR;
      end
      WR: begin
        bht_add2   = upd_word;
        bht_wen2   = 1'b1;
        bht_wdata2 = rmw_word;
        state_next = IDLE;
      end
      CLR: begin
        bht_add2   = clr_cnt_reg;
        bht_wen2   = 1'b1;
        bht_wdata2 = CLR_PAT;
        if (clr_cnt_reg == CNT_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      clr_pend_reg <= 1'b0;
      clr_cnt_reg  <= '0;
      slot_q_reg   <= '0;
      upd_q_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      slot_q_reg <= lkp_idx[SW-1:0];
      // A request arriving during the sweep is already covered by it.
      if ((state_reg == CLR) && (state_next == IDLE)) clr_pend_reg <= 1'b0;
      else if (clr_req && (state_reg != CLR))         clr_pend_reg <= 1'b1;
      if (flush)                   clr_cnt_reg <= '0;
      else if (state_reg == CLR)   clr_cnt_reg <= clr_cnt_reg + ADDR_ONE;
      if (pop) upd_q_reg <= fifo_mem[rd_ptr_reg];
    end
  end
endmodule

// File: tb/tb_dbp_bht_ctrl.sv
// Scoreboard bench for dbp_bht_ctrl: expected channel-2 writes are queued by the
// stimulus and consumed by a monitor; lookups and reset behaviour are checked inline.
module tb_dbp_bht_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = AW + SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] lkp_idx;
  logic [1:0]    lkp_ctr;
  logic          lkp_taken;
  logic          upd_valid;
  logic          upd_ready;
  logic [IW-1:0] upd_idx;
  logic          upd_taken;
  logic          clr_req;
  logic          busy;
  logic [AW-1:0] bht_add1;
  logic [DW-1:0] bht_rdata1;
  logic [AW-1:0] bht_add2;
  logic [DW-1:0] bht_rdata2;
  logic          bht_wen2;
  logic [DW-1:0] bht_wdata2;

  always #5 clk = ~clk;

  dbp_bht_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .lkp_idx    (lkp_idx),
    .lkp_ctr    (lkp_ctr),
    .lkp_taken  (lkp_taken),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .clr_req    (clr_req),
    .busy       (busy),
    .bht_add1   (bht_add1),
    .bht_rdata1 (bht_rdata1),
    .bht_add2   (bht_add2),
    .bht_rdata2 (bht_rdata2),
    .bht_wen2   (bht_wen2),
    .bht_wdata2 (bht_wdata2)
  );

  // Dual-port memory with registered reads; a write is invisible to a same-edge read.
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  always @(posedge clk) begin
    bht_rdata1 <= mem[bht_add1];
    bht_rdata2 <= mem[bht_add2];
    if (bht_wen2)     mem[bht_add2] <= bht_wdata2;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            clr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.clr  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every channel-2 write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bht_wen2) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", bht_add2, bht_wdata2);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bht_add2), 32'(mon_e.addr));
        check("wr_data", bht_wdata2, mon_e.data);
        if (mon_e.clr) check("ready_in_clr", 32'(upd_ready), 32'd0);
        else $display("[TB] write addr=%0d data=%h", bht_add2, bht_wdata2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [AW-1:0] w, input logic [SW-1:0] s, input logic t);
    bit acc;
    int n;
    upd_idx   = {w, s};
    upd_taken = t;
    upd_valid = 1'b1;
    n = 0;
    do begin
      acc = upd_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    upd_valid = 1'b0;
    stall_cycles += n - 1;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL upd_accept: got no handshake in %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic lookup(input string name, input logic [AW-1:0] w, input logic [SW-1:0] s,
                        input logic [1:0] req);
    lkp_idx = {w, s};
    tick();
    check(name, 32'(lkp_ctr), 32'(req));
    check({name, "_taken"}, 32'(lkp_taken), 32'(req[1]));
    $display("[TB] lookup word=%0d slot=%0d ctr=%0d", w, s, lkp_ctr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    lkp_idx   = '0;
    upd_valid = 1'b0;
    upd_idx   = '0;
    upd_taken = 1'b0;
    clr_req   = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_ready", 32'(upd_ready), 32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_wen2",  32'(bht_wen2),  32'd0);
    check("rst_add2",  32'(bht_add2),  32'd0);
    check("rst_wdata", bht_wdata2,     32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Single update: word 3 slot 2 taken from 0.
    exp_push(10'd3, 32'h0000_0010, 1'b0);
    do_upd(10'd3, 4'd2, 1'b1);
    tick();
    check("rd_add2", 32'(bht_add2), 32'd3);
    check("rd_wen2", 32'(bht_wen2), 32'd0);
    wait_idle(20);
    lookup("lkp_single", 10'd3, 4'd2, 2'd1);

    // Saturation with back-to-back updates; surrounding slots must survive.
    poke_addr = 10'd3;
    poke_data = 32'hC3A5_961F;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
    exp_push(10'd3, 32'hC3A5_962F, 1'b0);
    exp_push(10'd3, 32'hC3A5_963F, 1'b0);
    exp_push(10'd3, 32'hC3A5_963F, 1'b0);
    exp_push(10'd3, 32'hC3A5_963F, 1'b0);
    for (int i = 0; i < 4; i++) do_upd(10'd3, 4'd2, 1'b1);
    wait_idle(100);
    lookup("lkp_sat_hi", 10'd3, 4'd2, 2'd3);
    exp_push(10'd3, 32'hC3A5_962F, 1'b0);
    exp_push(10'd3, 32'hC3A5_961F, 1'b0);
    exp_push(10'd3, 32'hC3A5_960F, 1'b0);
    exp_push(10'd3, 32'hC3A5_960F, 1'b0);
    exp_push(10'd3, 32'hC3A5_960F, 1'b0);
    for (int i = 0; i < 5; i++) do_upd(10'd3, 4'd2, 1'b0);
    wait_idle(100);
    lookup("lkp_sat_lo", 10'd3, 4'd2, 2'd0);
    lookup("lkp_neighbor", 10'd3, 4'd0, 2'd3);

    // Backpressure: eight updates pushed as fast as the FIFO allows.
    stall_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      exp_push(AW'(20 + i), 32'h0000_0001, 1'b0);
      do_upd(AW'(20 + i), 4'd0, 1'b1);
    end
    check("backpressure_seen", 32'(stall_cycles > 0), 32'd1);
    wait_idle(100);
    lookup("lkp_bp_last", 10'd27, 4'd0, 2'd1);

    // Clear requested during RD: the write completes, then the sweep; queued updates vanish.
    exp_push(10'd40, 32'h0000_0004, 1'b0);
    for (int i = 0; i < (1 << AW); i++) exp_push(AW'(i), 32'h5555_5555, 1'b1);
    do_upd(10'd40, 4'd1, 1'b1);
    tick();
    check("clr_rd_state", 32'(bht_add2), 32'd40);
    clr_req   = 1'b1;
    upd_idx   = {10'd41, 4'd0};
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    tick();
    clr_req = 1'b0;
    upd_idx = {10'd42, 4'd0};
    tick();
    upd_idx = {10'd43, 4'd0};
    tick();
    upd_valid = 1'b0;
    check("clr_started", 32'(bht_wen2), 32'd1);
    wait_idle(1100);
    $display("[TB] clear sweep complete, %0d writes pending", exp_q.size());
    lookup("lkp_after_clr", 10'd41, 4'd0, 2'd1);
    lookup("lkp_clr_last", 10'd1023, 4'd15, 2'd1);

    // Lookup colliding with the write of the same word returns the old counter.
    exp_push(10'd7, 32'h5555_5556, 1'b0);
    do_upd(10'd7, 4'd0, 1'b1);
    tick();
    tick();
    check("coll_wr_phase", 32'(bht_wen2), 32'd1);
    lookup("lkp_coll_old", 10'd7, 4'd0, 2'd1);
    lookup("lkp_coll_new", 10'd7, 4'd0, 2'd2);
    wait_idle(20);

    // Async reset in the middle of a clear sweep.
    for (int i = 0; i < 100; i++) exp_push(AW'(i), 32'h5555_5555, 1'b1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    begin
      int n;
      n = 0;
      while (!(bht_wen2 && bht_add2 == 10'd100) && n < 200) begin
        tick();
        n++;
      end
    end
    check("clr_cnt100", 32'(bht_add2), 32'd100);
    #2 reset = 1'b0;
    #1;
    check("arst_wen2",  32'(bht_wen2),  32'd0);
    check("arst_add2",  32'(bht_add2),  32'd0);
    check("arst_wdata", bht_wdata2,     32'd0);
    check("arst_ready", 32'(upd_ready), 32'd1);
    check("arst_busy",  32'(busy),      32'd0);
    #3 reset = 1'b1;
    tick();
    check("post_rst_busy",  32'(busy),      32'd0);
    check("post_rst_ready", 32'(upd_ready), 32'd1);
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbp_bht_ctrl.md
# dbp_bht_ctrl

Sequencing controller for the dual-port branch history table (BHT) memory in the branch predictor. It owns both memory channels. Channel 1 serves single-cycle prediction lookups from fetch. Channel 2 serves read-modify-write updates of 2-bit saturating counters, queued from branch resolution in execute, plus a full-table clear sweep. Each memory word packs DWIDTH/2 counters.

## Interface
Parameters:
- AWIDTH, 10, BHT word-address width (memory depth 2**AWIDTH)
- DWIDTH, 32, BHT word width; holds DWIDTH/2 counters
- SW, 4, counter-slot select width, log2(DWIDTH/2)
- QDEPTH, 4, update FIFO depth (power of two)
- CLR_PAT, 32'h5555_5555, word written by clear (all counters 2'b01, weakly not-taken)

Ports:
- clk  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-low (0 = reset)
- lkp_idx  input  AWIDTH+SW  lookup index: [AWIDTH+SW-1:SW] word, [SW-1:0] slot
- lkp_ctr  output  2  looked-up counter, valid one cycle after lkp_idx
- lkp_taken  output  1  lkp_ctr[1]
- upd_valid  input  1  update request
- upd_ready  output  1  update accepted when upd_valid & upd_ready
- upd_idx  input  AWIDTH+SW  update index, same split as lkp_idx
- upd_taken  input  1  resolved direction
- clr_req  input  1  one-cycle pulse, request table clear
- busy  output  1  FSM not in IDLE or FIFO non-empty
- bht_add1  output  AWIDTH  to memory channel 1 address
- bht_rdata1  input  DWIDTH  memory channel 1 registered read data
- bht_add2  output  AWIDTH  to memory channel 2 address
- bht_rdata2  input  DWIDTH  memory channel 2 registered read data
- bht_wen2  output  1  memory channel 2 write enable
- bht_wdata2  output  DWIDTH  memory channel 2 write data

## Operation
Memory model: read data is registered, so an address presented in cycle t returns data in t+1. A write at an edge is not visible to a read sampled at the same edge.

Lookup:
- bht_add1 = lkp_idx word field, combinational.
- Slot is registered (slot_q). lkp_ctr = bht_rdata1[2*slot_q+1 : 2*slot_q].
- No forwarding from in-flight updates. A lookup of a word written in the same cycle returns the old value.

Update FIFO:
- QDEPTH entries of {idx, taken}.
- upd_ready = !full & state != CLR.
- Push on upd_valid & upd_ready. Pop when FSM leaves IDLE into RD.

FSM states: IDLE, RD, WR, CLR.
- IDLE: if clr_pend, go to CLR with clr_cnt=0 and flush FIFO. Else if FIFO non-empty, pop the head into upd_q and go to RD.
- RD: bht_add2 = upd_q word, bht_wen2=0. Next state is WR.
- WR: bht_add2 = upd_q word, bht_wen2=1. bht_wdata2 = bht_rdata2 with only slot upd_q.slot replaced:
  - taken: ctr==3 ? 3 : ctr+1
  - not taken: ctr==0 ? 0 : ctr-1
  - All other bits pass through unchanged. Next state is IDLE.
- CLR: bht_add2=clr_cnt, bht_wen2=1, bht_wdata2=CLR_PAT, clr_cnt increments each cycle. After writing address 2**AWIDTH-1, clear clr_pend and go to IDLE.

clr_req handling:
- Sets clr_pend in any state. An in-flight RD/WR completes first.
- clr_req during CLR is ignored; clr_pend is already being served.

## Timing
- Reset (async, reset=0) gives: state IDLE, FIFO empty, clr_pend=0, clr_cnt=0, slot_q=0, upd_q=0.
- Outputs during reset: upd_ready=1, busy=0, bht_wen2=0, bht_add2=0, bht_wdata2=0.
- Reset mid-RMW or mid-CLR aborts immediately. Partial clear is acceptable.
- Lookup latency is 1 cycle.
- Update latency:
  - Accepted at edge e into an empty FIFO with FSM in IDLE: RD in cycle e+1, write at the end of cycle e+2.
  - Sustained throughput is one update per 3 cycles (IDLE, RD, WR).
- Back-to-back updates to the same counter are correct: the next RD samples after the previous WR edge.
- FIFO full: upd_ready=0 and no push. A pop in the same cycle re-asserts upd_ready next cycle.
- Push and pop in the same cycle are allowed when not full.
- Clear occupies exactly 2**AWIDTH consecutive cycles of bht_wen2=1. upd_ready=0 throughout.
- Queued updates are dropped when the clear starts.
- bht_wen2 is never asserted outside WR and CLR.

## Test plan
- Reset then single update: memory word 3 = 0, upd_idx={3,4'd2}, taken=1. Expect RD cycle, then WR with bht_wdata2=32'h0000_0010. Lookup {3,2} one cycle later gives lkp_ctr=1.
- Saturation: four taken updates to counter at 3, then five not-taken updates to the same counter. Expect counter pinned at 3, then at 0. No other slot in the word changes.
- FIFO backpressure: hold upd_valid for 8 cycles with FSM stalled. Expect upd_ready=0 after 4 pushes, with 4-plus-pops accepted in order. Every update lands and none is duplicated.
- Clear mid-RMW: clr_req during RD. Expect WR to complete, then 1024 writes of 32'h5555_5555 at addresses 0..1023. Queued entries are dropped and upd_ready=0 throughout.
- Lookup/write collision: lookup word 7 in the same cycle WR writes word 7. Expect the old counter, and the new counter on a lookup the next cycle.
- Async reset in CLR at clr_cnt=100: outputs return to reset values without a clock edge. busy=0 and upd_ready=1 after release.
